sseg_arbiter: RTL
=================

SSEG_ARBITER -- requirements
Module: sseg_arbiter

Interface
REQ-001 Parameter N, default 18: scan counter width; one display frame = 2^N enabled cycles.
REQ-002 Parameter HOLD, default 4: minimum frames an owner keeps the display once another requester is waiting; range 1..15.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  scan enable; counter, frame and arbitration logic advance only when en=1.
REQ-006 req0  input  1  requester 0 asks for the display (level).
REQ-007 req1  input  1  requester 1 asks for the display (level).
REQ-008 data0  input  16  requester 0 hex value, digit 3 = [15:12] ... digit 0 = [3:0].
REQ-009 data1  input  16  requester 1 hex value, same packing.
REQ-010 gnt  output  2  one-hot grant; bit i = requester i owns the display; 00 = idle.
REQ-011 an  output  4  digit anodes, active low; an[k] drives digit k.
REQ-012 sseg  output  8  segments, active low; [7]=dp, [6:0]={g,f,e,d,c,b,a}.

Function
REQ-013 Scan counter q (N bits) shall increment by 1 each enabled cycle, wrapping 2^N-1 -> 0; held when en=0.
REQ-014 Digit select shall be q[N-1:N-2]; value k drives an = all ones except bit k low.
REQ-015 frame_tick shall be asserted when en=1 and q = 2^N-1; all arbitration decisions occur only on frame_tick.
REQ-016 FSM states: IDLE, OWN0, OWN1; gnt = 00 / 01 / 10 respectively, registered.
REQ-017 IDLE on frame_tick: req0 only -> OWN0; req1 only -> OWN1; both -> requester not equal to last_owner; neither -> stay IDLE.
REQ-018 last_owner (1 bit) shall update to i on every entry to OWNi.
REQ-019 OWNi on frame_tick: own req dropped -> other requester if it is requesting, else IDLE.
REQ-020 OWNi on frame_tick with own req held and other requesting: switch to other owner when hold_cnt >= HOLD, else stay.
REQ-021 OWNi with own req held and other not requesting: stay indefinitely.
REQ-022 hold_cnt (4 bits) shall clear on every owner change and increment on each frame_tick while owning, saturating at 15.
REQ-023 Frame register fbuf (16 bits) shall load the new owner's data on the frame_tick that grants or keeps ownership; it is held constant for the whole following frame (no tearing).
REQ-024 In OWNi, sseg[6:0] shall be the hex decode of fbuf nibble selected by digit select; sseg[7]=1 (dp off).
REQ-025 Hex decode (active-low {g..a}): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-026 In IDLE, an shall be 1111 and sseg 11111111 (blank).
REQ-027 Requests asserted/deasserted between frame_ticks have no effect until the next frame_tick; a pulse fully between two ticks is ignored.
REQ-028 en=0 shall freeze q, FSM, hold_cnt, fbuf; outputs keep their current values.

Reset
REQ-029 Reset asserted shall immediately force q=0, state=IDLE, gnt=00, last_owner=1, hold_cnt=0, fbuf=0, an=1111, sseg=FF, regardless of clk.
REQ-030 Reset mid-frame or mid-ownership shall discard ownership; after release first grant occurs at the first frame_tick (2^N enabled cycles later); simultaneous req0 and req1 then grant requester 0.

Verification (N=4, HOLD=2, en=1)
REQ-031 Reset, req0=1, data0=0x12AF -> gnt=01 after cycle 16; next frame an sequence 1110,1101,1011,0111 each 4 cycles with sseg 10001110,10001000,10100100,11111001.
REQ-032 req0=req1=1 from reset -> OWN0 for frames 1-2, OWN1 from frame-3 tick, back to OWN0 two frames later (strict alternation).
REQ-033 OWN0, req0 drops at cycle 5 of a frame, req1=0 -> gnt stays 01 until frame end, then 00 and blank display.
REQ-034 OWN0, data0 changes mid-frame from 0x0000 to 0xFFFF -> sseg shows 0 digits until frame end, F digits from next frame.
REQ-035 en=0 for 10 cycles mid-frame -> an/sseg/gnt unchanged; frame_tick delayed by exactly 10 cycles.
REQ-036 Reset asserted asynchronously between clock edges while OWN1 -> gnt=00, an=1111, sseg=FF before next clk edge.

Source files
------------

// File: rtl/sseg_arbiter.sv
// Two-requester arbiter for a shared 4-digit seven-segment display.
// Ownership changes only at frame boundaries; the shown value is latched per frame.
module sseg_arbiter #(
    parameter int N    = 18,
    parameter int HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  gnt,
    output logic [3:0]  an,
    output logic [7:0]  sseg
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [N-1:0] ONE    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [3:0]   HOLD_L = 4'(HOLD);

    logic [N-1:0] q_q, q_d;
    state_t       state_q, state_d;
    logic         last_q, last_d;
    logic [3:0]   hold_q, hold_d;
    logic [15:0]  fbuf_q, fbuf_d;

    logic         frame_tick;
    logic [3:0]   hold_inc;
    logic [1:0]   digit;
    logic [3:0]   nib;
    logic [6:0]   seg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= '0;
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
            fbuf_q  <= '0;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            fbuf_q  <= fbuf_d;
        end
    end

    // hold_inc counts the frame just finishing, so HOLD=2 yields two full frames
    always_comb begin
        q_d        = q_q;
        state_d    = state_q;
        last_d     = last_q;
        hold_d     = hold_q;
        fbuf_d     = fbuf_q;
        frame_tick = en && (q_q == '1);
        hold_inc   = (hold_q == 4'hF) ? 4'hF : hold_q + 4'd1;
        if (en) q_d = q_q + ONE;
        if (frame_tick) begin
            case (state_q)
                IDLE: begin
                    if (req0 && req1) state_d = last_q ? OWN0 : OWN1;
                    else if (req0)    state_d = OWN0;
                    else if (req1)    state_d = OWN1;
                end
                OWN0: begin
                    if (!req0)                          state_d = req1 ? OWN1 : IDLE;
                    else if (req1 && hold_inc >= HOLD_L) state_d = OWN1;
                end
                OWN1: begin
                    if (!req1)                          state_d = req0 ? OWN0 : IDLE;
                    else if (req0 && hold_inc >= HOLD_L) state_d = OWN0;
                end
                default: state_d = IDLE;
            endcase
            if (state_d == state_q && state_q != IDLE) hold_d = hold_inc;
            else                                       hold_d = '0;
            if (state_d == OWN0) begin
                fbuf_d = data0;
                last_d = 1'b0;
            end else if (state_d == OWN1) begin
                fbuf_d = data1;
                last_d = 1'b1;
            end
        end
    end

    assign digit = q_q[N-1:N-2];

    always_comb begin
        case (digit)
            2'd0:    nib = fbuf_q[3:0];
            2'd1:    nib = fbuf_q[7:4];
            2'd2:    nib = fbuf_q[11:8];
            default: nib = fbuf_q[15:12];
        endcase
    end

    always_comb begin
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end

    always_comb begin
        gnt  = 2'b00;
        an   = 4'hF;
        sseg = 8'hFF;
        case (state_q)
            OWN0: gnt = 2'b01;
            OWN1: gnt = 2'b10;
            default: gnt = 2'b00;
        endcase
        if (state_q != IDLE) begin
            an   = ~(4'b0001 << digit);
            sseg = {1'b1, seg};
        end
    end

endmodule
